// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: 16-byte register window, byte FIFO, 8N1 framing.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 framing); the register map does not change.
//
// state  | meaning
// IDLE   | line high, waiting for a byte in the FIFO
// START  | driving the start bit (0)
// DATA   | driving 8 data bits, LSB first
// PARITY | driving the even-parity bit (UART_TX_PARITY_EN only)
// STOP   | driving the stop bit (1); chains straight into START if more bytes wait
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_AW     = 3,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        tx
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state, state_n;

    logic [15:0]        div_reg;
    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               full, empty;
    logic               push, pop;

    logic               sel, is_write, stall, accept;
    logic [1:0]         off;
    logic [31:0]        rdata_w, status_w;

    logic [15:0]        cnt, cnt_n;
    logic [15:0]        frame_div, frame_div_n, div_eff;
    logic [7:0]         shift, shift_n;
    logic [2:0]         bit_idx, bit_idx_n;
    logic               par, par_n;
    logic               tx_n;
    logic               load_frame;

    logic               unused_ok;
    assign unused_ok = ^{mem_addr[1:0], mem_wdata[31:16]};

    assign sel      = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign off      = mem_addr[3:2];
    assign is_write = |mem_wstrb;
    // level can never exceed DEPTH, so its MSB alone marks full
    assign full     = level[FIFO_AW];
    assign empty    = (level == '0);
    assign stall    = sel && is_write && (off == 2'd0) && mem_wstrb[0] && full;
    assign accept   = sel && !mem_ready && !stall;
    assign push     = accept && is_write && (off == 2'd0) && mem_wstrb[0];

    always_comb begin
        status_w = '0;
        status_w[0] = (state != IDLE);
        status_w[1] = full;
        status_w[2] = empty;
        status_w[4 +: FIFO_AW+1] = level;
    end

    always_comb begin
        rdata_w = '0;
        case (off)
            2'd1:    rdata_w = {16'd0, div_reg};
            2'd2:    rdata_w = status_w;
            default: rdata_w = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            div_reg   <= DEFAULT_DIV;
        end else begin
            mem_ready <= accept;
            mem_rdata <= (accept && !is_write) ? rdata_w : 32'd0;
            if (accept && is_write && (off == 2'd1) && (|mem_wstrb[1:0]))
                div_reg <= mem_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= mem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign div_eff = (div_reg == 16'd0) ? 16'd1 : div_reg;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        frame_div_n = frame_div;
        shift_n     = shift;
        bit_idx_n   = bit_idx;
        par_n       = par;
        load_frame  = 1'b0;
        pop         = 1'b0;
        tx_n        = 1'b1;

        case (state)
            IDLE: begin
                if (!empty) load_frame = 1'b1;
            end
            START: begin
                if (cnt == 16'd0) begin
                    state_n   = DATA;
                    cnt_n     = frame_div - 16'd1;
                    bit_idx_n = 3'd0;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == 16'd0) begin
                    cnt_n   = frame_div - 16'd1;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt == 16'd0) begin
                    state_n = STOP;
                    cnt_n   = frame_div - 16'd1;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt == 16'd0) begin
                    if (!empty) load_frame = 1'b1;
                    else        state_n    = IDLE;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // divider is sampled only here, so DIV writes mid-frame wait for the next frame
        if (load_frame) begin
            pop         = 1'b1;
            state_n     = START;
            shift_n     = fifo_mem[rd_ptr];
            par_n       = ^fifo_mem[rd_ptr];
            frame_div_n = div_eff;
            cnt_n       = div_eff - 16'd1;
        end

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_div <= 16'd1;
            shift     <= '0;
            bit_idx   <= '0;
            par       <= 1'b0;
            tx        <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            frame_div <= frame_div_n;
            shift     <= shift_n;
            bit_idx   <= bit_idx_n;
            par       <= par_n;
            tx        <= tx_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register-access vector table plus frame, stall and reset sequences.
// Build with UART_TX_PARITY_EN defined to check the 11-bit framing instead.
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        tx;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    uart_tx_mmio dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .tx        (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        exp_ready;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int maxc, output logic got, output logic [31:0] rd, output int ncyc);
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        got = 1'b0; rd = '0; ncyc = 0;
        while (!got && ncyc < maxc) begin
            @(posedge clk); #1;
            ncyc++;
            if (mem_ready) begin
                got = 1'b1;
                rd  = mem_rdata;
            end
        end
        mem_valid = 1'b0; mem_wstrb = '0;
    endtask

    task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d);
        logic g; logic [31:0] r; int n;
        bus(a, d, 4'hF, 3000, g, r, n);
        check({name, "_ready"}, {31'd0, g}, 32'd1);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic g; logic [31:0] r; int n;
        bus(a, 32'd0, 4'h0, 20, g, r, n);
        check({name, "_ready"}, {31'd0, g}, 32'd1);
        check(name, r, exp);
    endtask

    task automatic check_frame(input string name, input logic [7:0] b, input int div);
        logic bits [11];
        int nb, w, bad, first_bad;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        bits[9] = ^b; bits[10] = 1'b1; nb = 11;
`else
        bits[9] = 1'b1; bits[10] = 1'b1; nb = 10;
`endif
        w = 0;
        while (tx !== 1'b0 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check({name, "_start_seen"}, {31'd0, tx}, 32'd0);
        bad = 0; first_bad = -1;
        for (int i = 0; i < nb * div; i++) begin
            if (tx !== bits[i / div]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
            @(posedge clk); #1;
        end
        if (bad != 0) $display("  %s first bad sample at cycle %0d", name, first_bad);
        check({name, "_bit_errs"}, bad, 0);
        check({name, "_idle_after"}, {31'd0, tx}, 32'd1);
        rd_chk({name, "_status_after"}, BASE + 32'h8, 32'h4);
    endtask

    vec_t vecs [14];

    initial begin
        logic g; logic [31:0] r; int n;
        int stalls, done1, done10;
        logic [7:0] v;

        vecs[0]  = '{BASE + 32'h8,  32'h0,         4'h0, 1'b1, 1'b1, 32'h4};
        vecs[1]  = '{BASE + 32'h4,  32'h0,         4'h0, 1'b1, 1'b1, 32'd868};
        vecs[2]  = '{BASE + 32'h0,  32'h0,         4'h0, 1'b1, 1'b1, 32'h0};
        vecs[3]  = '{BASE + 32'hC,  32'h0,         4'h0, 1'b1, 1'b1, 32'h0};
        vecs[4]  = '{BASE + 32'hC,  32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{BASE + 32'hC,  32'h0,         4'h0, 1'b1, 1'b1, 32'h0};
        vecs[6]  = '{BASE + 32'h4,  32'hABCD_1234, 4'hF, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{BASE + 32'h4,  32'h0,         4'h0, 1'b1, 1'b1, 32'h1234};
        vecs[8]  = '{BASE + 32'h4,  32'h0000_5678, 4'hC, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{BASE + 32'h4,  32'h0,         4'h0, 1'b1, 1'b1, 32'h1234};
        vecs[10] = '{BASE + 32'h10, 32'h0,         4'h0, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{32'h2000_0004, 32'h0000_0042, 4'hF, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{BASE + 32'h4,  32'h0,         4'h0, 1'b1, 1'b1, 32'h1234};
        vecs[13] = '{BASE + 32'h9,  32'h0,         4'h0, 1'b1, 1'b1, 32'h4};

        resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);

        for (int i = 0; i < 14; i++) begin
            bus(vecs[i].addr, vecs[i].wdata, vecs[i].strb, 6, g, r, n);
            check($sformatf("vec%0d_ready", i), {31'd0, g}, {31'd0, vecs[i].exp_ready});
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rd);
        end

        // DIV=4, 0x55: alternating 0/1 line, 40 cycles
        wr("div4", BASE + 32'h4, 32'd4);
        wr("data55", BASE + 32'h0, 32'h55);
        check_frame("frame55", 8'h55, 4);

        // DIV=2, 0x07: parity 1 in the parity build (22 cycles), 20 cycles otherwise
        wr("div2", BASE + 32'h4, 32'd2);
        wr("data07", BASE + 32'h0, 32'h07);
        check_frame("frame07", 8'h07, 2);

        // DIV=0 behaves as 1 but reads back as written
        wr("div0", BASE + 32'h4, 32'd0);
        rd_chk("div0_rd", BASE + 32'h4, 32'd0);
        wr("dataFF", BASE + 32'h0, 32'hFF);
        check_frame("frameFF", 8'hFF, 1);

        // DIV=100, ten back-to-back writes into an 8-deep FIFO
        wr("div100", BASE + 32'h4, 32'd100);
        stalls = 0; done1 = 0;
        for (int i = 0; i < 9; i++) begin
            v = 8'(8'h30 + i);
            bus(BASE, {24'd0, v}, 4'h1, 3000, g, r, n);
            if (i == 0) done1 = cyc;
            if (!g || n != 1) stalls++;
        end
        check("b2b_w1to9_stalls", stalls, 0);
        bus(BASE, 32'h39, 4'h1, 3000, g, r, n);
        done10 = cyc;
        check("b2b_w10_ready", {31'd0, g}, 32'd1);
        check("b2b_w10_release", done10 - done1, 1002);
        check("b2b_next_start", {31'd0, tx}, 32'd0);
        rd_chk("b2b_status_full", BASE + 32'h8, 32'h83);

        // reset mid-frame with 3 bytes queued
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        wr("rst_div20", BASE + 32'h4, 32'd20);
        for (int i = 0; i < 4; i++)
            wr($sformatf("rst_q%0d", i), BASE, 32'h11 * (i + 1));
        repeat (30) @(posedge clk);
        #1;
        check("pre_rst_in_data", {31'd0, tx}, 32'd1);
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        check("post_rst_tx", {31'd0, tx}, 32'd1);
        check("post_rst_ready", {31'd0, mem_ready}, 32'd0);
        rd_chk("post_rst_status", BASE + 32'h8, 32'h4);
        rd_chk("post_rst_div", BASE + 32'h4, 32'd868);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) n++;
        end
        check("post_rst_line_idle", n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
